// File: rtl/spi_arb_pkg.sv
// Shared types for the SPI transaction arbiter: FSM state encoding and byte-count width helper.
// Pure declarations; no logic, no latency, no flow control.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_RX = 2'd2,
    DONE    = 2'd3
  } arb_state_e;

  function automatic int cnt_width(input int max_bytes);
    return $clog2(max_bytes + 1);
  endfunction

endpackage

// File: rtl/spi_rr_picker.sv
// Round-robin picker: first set request at or after i_ptr (wrapping), one-hot result.
// Purely combinational, zero latency; no backpressure (o_vld simply mirrors any request).
module spi_rr_picker #(
  parameter int NUM_REQ = 2,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_pick,
  output logic               o_vld
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] pick_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [NUM_REQ-1:0]   pick_rot;

  // Rotate so the pointer sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    req_dbl  = {i_req, i_req} >> i_ptr;
    req_rot  = req_dbl[NUM_REQ-1:0];
    pick_rot = req_rot & (~req_rot + NUM_REQ'(1));
    pick_dbl = {{NUM_REQ{1'b0}}, pick_rot} << i_ptr;
    o_pick   = pick_dbl[NUM_REQ-1:0] | pick_dbl[2*NUM_REQ-1:NUM_REQ];
    o_vld    = |i_req;
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI master among NUM_REQ requesters, round-robin per chip-select transaction.
// Grant 1 cycle after request; TX/RX strobes 1 cycle after handshake; bytes stall on i_TX_Ready.
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ          = 2,
  parameter int MAX_BYTES_PER_CS = 2,
  localparam int CW              = cnt_width(MAX_BYTES_PER_CS)
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic [NUM_REQ-1:0]    i_Req,
  input  logic [NUM_REQ*CW-1:0] i_Req_Count,
  input  logic [NUM_REQ*8-1:0]  i_Req_Byte,
  input  logic [NUM_REQ-1:0]    i_Req_DV,
  output logic [NUM_REQ-1:0]    o_Grant,
  output logic [NUM_REQ-1:0]    o_Byte_Ready,
  output logic [NUM_REQ-1:0]    o_RX_DV,
  output logic [7:0]            o_RX_Byte,
  output logic [NUM_REQ-1:0]    o_Done,
  output logic [CW-1:0]         o_TX_Count,
  output logic [7:0]            o_TX_Byte,
  output logic                  o_TX_DV,
  input  logic                  i_TX_Ready,
  input  logic                  i_RX_DV,
  input  logic [7:0]            i_RX_Byte
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BYTES_PER_CS);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] rx_dv_q, rx_dv_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]      tx_count_q, tx_count_d;
  logic [CW-1:0]      byte_cnt_q, byte_cnt_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic [7:0]         rx_byte_q, rx_byte_d;
  logic               tx_dv_q, tx_dv_d;

  logic [NUM_REQ-1:0] pick;
  logic               pick_vld;
  logic [IW-1:0]      pick_idx;
  logic [CW-1:0]      pick_count_raw, pick_count;
  logic [7:0]         req_byte_sel;
  logic [CW-1:0]      byte_cnt_inc;
  logic               byte_accept;
  logic               last_byte;

  spi_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .i_req  (i_Req),
    .i_ptr  (rr_ptr_q),
    .o_pick (pick),
    .o_vld  (pick_vld)
  );

  // One-hot muxes: pick drives the IDLE latch, grant drives the byte path.
  always_comb begin
    pick_count_raw = '0;
    pick_idx       = '0;
    req_byte_sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick[k]) begin
        pick_count_raw = i_Req_Count[k*CW +: CW];
        pick_idx       = IW'(k);
      end
      if (grant_q[k]) begin
        req_byte_sel = i_Req_Byte[k*8 +: 8];
      end
    end
    pick_count = (pick_count_raw > MAX_CNT) ? MAX_CNT : pick_count_raw;
  end

  assign o_Byte_Ready = (state_q == SEND) ? (grant_q & {NUM_REQ{i_TX_Ready}}) : '0;
  assign byte_accept  = |(i_Req_DV & o_Byte_Ready);
  assign byte_cnt_inc = byte_cnt_q + CW'(1);
  assign last_byte    = (byte_cnt_inc == tx_count_q);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rx_dv_q    <= '0;
      done_q     <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      tx_count_q <= '0;
      byte_cnt_q <= '0;
      tx_byte_q  <= '0;
      rx_byte_q  <= '0;
      tx_dv_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rx_dv_q    <= rx_dv_d;
      done_q     <= done_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      tx_count_q <= tx_count_d;
      byte_cnt_q <= byte_cnt_d;
      tx_byte_q  <= tx_byte_d;
      rx_byte_q  <= rx_byte_d;
      tx_dv_q    <= tx_dv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = (pick_count == '0) ? DONE : SEND;
      SEND:    if (byte_accept) state_d = WAIT_RX;
      WAIT_RX: if (i_RX_DV) state_d = last_byte ? DONE : SEND;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    tx_count_d = tx_count_q;
    byte_cnt_d = byte_cnt_q;
    tx_byte_d  = tx_byte_q;
    rx_byte_d  = rx_byte_q;
    tx_dv_d    = 1'b0;
    rx_dv_d    = '0;
    done_d     = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d    = pick;
          gidx_d     = pick_idx;
          tx_count_d = pick_count;
          byte_cnt_d = '0;
        end
      end
      SEND: begin
        if (byte_accept) begin
          tx_byte_d = req_byte_sel;
          tx_dv_d   = 1'b1;
        end
      end
      WAIT_RX: begin
        if (i_RX_DV) begin
          rx_byte_d  = i_RX_Byte;
          rx_dv_d    = grant_q;
          byte_cnt_d = byte_cnt_inc;
        end
      end
      DONE: begin
        done_d   = grant_q;
        grant_d  = '0;
        rr_ptr_d = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + IW'(1);
      end
      default: ;
    endcase
  end

  assign o_Grant    = grant_q;
  assign o_RX_DV    = rx_dv_q;
  assign o_RX_Byte  = rx_byte_q;
  assign o_Done     = done_q;
  assign o_TX_Count = tx_count_q;
  assign o_TX_Byte  = tx_byte_q;
  assign o_TX_DV    = tx_dv_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: directed vector table, hand corner sequences, randomized scoreboard run.
module tb_spi_txn_arbiter;
  localparam int N    = 2;
  localparam int MAXB = 2;
  localparam int CW   = $clog2(MAXB + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req, req_dv;
  logic [N*CW-1:0] req_cnt;
  logic [N*8-1:0]  req_byte;
  logic [N-1:0]    grant, byte_rdy, rx_dv_o, done;
  logic [7:0]      rx_byte_o, tx_byte, rx_byte_i;
  logic [CW-1:0]   tx_cnt;
  logic            tx_dv, tx_rdy, rx_dv_i;

  int checks = 0;
  int passed = 0;

  spi_txn_arbiter #(.NUM_REQ(N), .MAX_BYTES_PER_CS(MAXB)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Req(req), .i_Req_Count(req_cnt), .i_Req_Byte(req_byte),
    .i_Req_DV(req_dv), .o_Grant(grant), .o_Byte_Ready(byte_rdy), .o_RX_DV(rx_dv_o),
    .o_RX_Byte(rx_byte_o), .o_Done(done), .o_TX_Count(tx_cnt), .o_TX_Byte(tx_byte),
    .o_TX_DV(tx_dv), .i_TX_Ready(tx_rdy), .i_RX_DV(rx_dv_i), .i_RX_Byte(rx_byte_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " grant"}, grant, 0);
    chk({tag, " byte_ready"}, byte_rdy, 0);
    chk({tag, " rx_dv"}, rx_dv_o, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " tx_dv"}, tx_dv, 0);
    chk({tag, " tx_byte"}, tx_byte, 0);
    chk({tag, " rx_byte"}, rx_byte_o, 0);
    chk({tag, " tx_count"}, tx_cnt, 0);
  endtask

  task automatic do_reset(input bit check);
    rst = 1'b1; req = '0; req_dv = '0; req_cnt = '0; req_byte = '0;
    tx_rdy = 1'b0; rx_dv_i = 1'b0; rx_byte_i = '0;
    repeat (2) tick();
    if (check) chk_idle("reset");
    rst = 1'b0;
  endtask

  // One full transaction: requests rq, expects grant exp_g with exp_n bytes moved.
  task automatic run_txn(input logic [N-1:0] rq, input logic [N-1:0] exp_g, input int cnt_in,
                         input int exp_n, input logic [31:0] txw, input logic [31:0] rxw,
                         input bit stall, input bit drop, input string tag);
    int k = 0, ntx = 0, nrx = 0, ndone = 0, cyc = 0, done_cyc = -1;
    for (int j = 0; j < N; j++) if (exp_g[j]) k = j;
    req = rq; req_dv = '0; tx_rdy = 1'b1; rx_dv_i = 1'b0;
    for (int j = 0; j < N; j++) req_cnt[j*CW +: CW] = CW'(cnt_in);
    tick();
    chk({tag, " grant"}, grant, exp_g);
    chk({tag, " tx_count"}, tx_cnt, exp_n);
    req_byte = {N{8'hEE}};
    req_byte[k*8 +: 8] = txw[7:0];
    req_dv = '1;
    if (stall) begin
      tx_rdy = 1'b0; rx_dv_i = 1'b1; rx_byte_i = 8'h99;
      #1;
      chk({tag, " byte_ready while master busy"}, byte_rdy, 0);
      tick(); cyc++;
      chk({tag, " tx_dv while stalled"}, tx_dv, 0);
      chk({tag, " stray rx_dv in SEND"}, rx_dv_o, 0);
      rx_dv_i = 1'b0; tx_rdy = 1'b1;
      #1;
      chk({tag, " byte_ready granted only"}, byte_rdy, exp_g);
    end
    while (ndone == 0 && cyc < 40) begin
      tick(); cyc++;
      rx_dv_i = 1'b0;
      if (tx_dv) begin
        chk({tag, " tx_byte"}, tx_byte, txw[ntx*8 +: 8]);
        rx_dv_i = 1'b1;
        rx_byte_i = rxw[ntx*8 +: 8];
        ntx++;
        req_byte[k*8 +: 8] = txw[ntx*8 +: 8];
        if (drop) req[k] = 1'b0;
      end
      if (rx_dv_o != 0) begin
        chk({tag, " rx_dv lane"}, rx_dv_o, exp_g);
        chk({tag, " rx_byte"}, rx_byte_o, rxw[nrx*8 +: 8]);
        nrx++;
      end
      if (done != 0) begin
        chk({tag, " done lane"}, done, exp_g);
        chk({tag, " grant cleared at done"}, grant, 0);
        chk({tag, " tx_count held"}, tx_cnt, exp_n);
        ndone++;
        done_cyc = cyc;
      end
    end
    chk({tag, " bytes sent"}, ntx, exp_n);
    chk({tag, " bytes received"}, nrx, exp_n);
    chk({tag, " done pulses"}, ndone, 1);
    chk({tag, " done cycle after grant"}, done_cyc, 2 * exp_n + 1 + int'(stall));
    req = '0; req_dv = '0; rx_dv_i = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] rq;
    int           cnt;
    logic [N-1:0] exp_g;
    int           exp_n;
  } vec_t;

  vec_t tbl[6];

  logic [N-1:0] pend, rprev, gprev;
  int           tcnt[N];
  int           sent[N];
  logic [7:0]   tbyte[N][4];
  logic [7:0]   sbyte;
  int           ptr_m, g, ecnt, nrx_r, sdelay, txns;
  bit           found;

  initial begin
    tbl[0] = '{2'b11, 1, 2'b01, 1};
    tbl[1] = '{2'b11, 1, 2'b10, 1};
    tbl[2] = '{2'b11, 2, 2'b01, 2};
    tbl[3] = '{2'b01, 0, 2'b01, 0};
    tbl[4] = '{2'b10, 3, 2'b10, 2};
    tbl[5] = '{2'b10, 0, 2'b10, 0};

    do_reset(1'b1);
    for (int i = 0; i < 6; i++)
      run_txn(tbl[i].rq, tbl[i].exp_g, tbl[i].cnt, tbl[i].exp_n,
              32'h4433_2211 + 32'(i * 32'h0101_0101), 32'hC0B0_A090 - 32'(i),
              1'b0, 1'b0, $sformatf("vec%0d", i));

    run_txn(2'b10, 2'b10, 2, 2, 32'h0000_3CA5, 32'h0000_C35A, 1'b0, 1'b0, "req1 two bytes");
    run_txn(2'b01, 2'b01, 1, 1, 32'h0000_0081, 32'h0000_0018, 1'b1, 1'b0, "stall");
    run_txn(2'b01, 2'b01, 2, 2, 32'h0000_6D5E, 32'h0000_F00F, 1'b0, 1'b1, "req drop");

    // Abort in WAIT_RX; pointer is 1 here, so the post-reset grant proves it was cleared.
    req = 2'b10; for (int j = 0; j < N; j++) req_cnt[j*CW +: CW] = CW'(2);
    tx_rdy = 1'b1;
    tick();
    chk("abort grant", grant, 2'b10);
    req_dv = '1; req_byte[8 +: 8] = 8'h77;
    tick();
    chk("abort tx_dv", tx_dv, 1);
    rst = 1'b1; rx_dv_i = 1'b1; rx_byte_i = 8'h42;
    tick();
    chk_idle("reset in WAIT_RX");
    rst = 1'b0; rx_dv_i = 1'b0; req = '0; req_dv = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no done after abort", done, 0);
    end
    run_txn(2'b11, 2'b01, 1, 1, 32'h0000_00AB, 32'h0000_00BA, 1'b0, 1'b0, "post-reset rr");

    // Randomized run against a transaction-level model.
    do_reset(1'b0);
    ptr_m = 0; gprev = '0; pend = '0; txns = 0; sdelay = 0; g = 0; ecnt = 0; nrx_r = 0;
    sbyte = '0;
    for (int k = 0; k < N; k++) begin tcnt[k] = 0; sent[k] = 0; end
    for (int c = 0; c < 4000 && txns < 40; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(0, 3) == 0) begin
          pend[k] = 1'b1;
          tcnt[k] = $urandom_range(0, 3);
          sent[k] = 0;
          for (int b = 0; b < 4; b++) tbyte[k][b] = 8'($urandom);
        end
        req[k] = pend[k] && !(grant[k] && sent[k] > 0 && $urandom_range(0, 1) == 1);
        req_cnt[k*CW +: CW] = CW'(tcnt[k]);
        req_dv[k] = 1'($urandom_range(0, 1));
        req_byte[k*8 +: 8] = grant[k] ? tbyte[k][sent[k] % 4] : 8'($urandom);
      end
      tx_rdy = ($urandom_range(0, 3) != 0);
      rx_dv_i = 1'b0;
      if (sdelay > 0) begin
        sdelay--;
        if (sdelay == 0) begin rx_dv_i = 1'b1; rx_byte_i = sbyte; end
      end
      rprev = req;
      tick();
      if (grant != 0 && gprev == 0) begin
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (!found && rprev[(ptr_m + i) % N]) begin g = (ptr_m + i) % N; found = 1'b1; end
        end
        chk("rand grant", grant, found ? (1 << g) : 0);
        ecnt = (tcnt[g] > MAXB) ? MAXB : tcnt[g];
        chk("rand tx_count", tx_cnt, ecnt);
        nrx_r = 0;
      end
      if (tx_dv) begin
        chk("rand tx_byte", tx_byte, tbyte[g][sent[g] % 4]);
        sent[g]++;
        sdelay = $urandom_range(1, 3);
        sbyte = 8'($urandom);
      end
      if (rx_dv_o != 0) begin
        chk("rand rx_dv lane", rx_dv_o, 1 << g);
        chk("rand rx_byte", rx_byte_o, sbyte);
        nrx_r++;
      end
      if (done != 0) begin
        chk("rand done lane", done, 1 << g);
        chk("rand bytes sent", sent[g], ecnt);
        chk("rand bytes received", nrx_r, ecnt);
        pend[g] = 1'b0;
        ptr_m = (g + 1) % N;
        txns++;
      end
      gprev = grant;
    end
    chk("rand transactions completed", txns >= 40, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
